manchester_serial_rx: RTL and testbench
=======================================

// Module: manchester_serial_rx
// PURPOSE
//  Serial Manchester receiver; downstream of the byte-wide Manchester encoder once its 16-bit code word is on a wire.
//  Samples a single serial line, finds a start symbol and decodes 8 bit cells MSB first.
//  Checks each cell for code violations and presents the recovered byte with a one-cycle strobe.
//  Mode polarity matches the encoder: mode=0 bit 1 = high-then-low; mode=1 bit 1 = low-then-high.
// PARAMETERS
//  HALF_BIT   4   clk cycles per half bit cell; even, >=4
//  DATA_BITS  8   data cells per frame
// PORTS
//  clk         in   1          single clock, rising edge
//  rst_n       in   1          asynchronous, active-low reset
//  line_in     in   1          serial Manchester line, asynchronous to clk
//  mode        in   1          polarity select, latched at frame start
//  data_out    out  DATA_BITS  last good byte; held until the next good frame
//  data_valid  out  1          1-cycle pulse when data_out updates
//  code_err    out  1          1-cycle pulse: frame ended with >=1 invalid cell
//  busy        out  1          high from start detect to end of frame
// BEHAVIOUR
//  Reset (async): state=IDLE; sync flops, data_out, data_valid, code_err, busy, counters = 0.
//  line_in passes a 2-flop synchronizer; "line" below means its output; prev = line delayed 1 clk.
//  Frame format: idle low -> start symbol (high for two halves) -> DATA_BITS cells -> line idles low.
//  Sample timing: T0 = first cycle with line=1 && prev=0 in IDLE.
//   Sample k is taken at T0 + k*HALF_BIT + HALF_BIT/2, k = 0 .. 2*DATA_BITS+1.
//   No mid-frame resynchronisation.
//  FSM states:
//   IDLE:  on rising edge: clear cnt, latch mode, set busy -> START.
//   START: samples k=0,1 must both be 1. Either 0 -> IDLE, busy=0, no pulse (glitch reject).
//   DATA:  pairs (k=2i+2, 2i+3) form cell i.
//    Valid pair "10"/"01" decodes per latched mode and shifts into the shift register MSB first.
//    Invalid pair "00"/"11" sets a sticky err flag and shifts in 0.
//   DONE:  one cycle, entered the cycle after sample k=2*DATA_BITS+1.
//    err=0: data_out<=shift register, data_valid=1. err=1: code_err=1, data_out unchanged.
//    Exactly one of the two pulses fires per completed frame. Then busy=0, err cleared -> IDLE.
//  Latency: pulse at T0 + (2*DATA_BITS+1)*HALF_BIT + HALF_BIT/2 + 1 (HALF_BIT=4: T0+71).
//  Line stuck high after a frame: no new start until line returns low, then rises again.
//  mode change mid-frame is ignored; the latched value applies.
//  rst_n low mid-frame aborts immediately: no pulse, outputs cleared.
//  Arithmetic: cnt is $clog2(HALF_BIT) bits, wraps at HALF_BIT-1.
//   Half counter is $clog2(2*DATA_BITS+2) bits.
// STRUCTURE
//  manchester_pkg: state encoding IDLE/START/DATA/DONE, MODE_THOMAS=0, MODE_IEEE=1, frame length constants.
//  Sub-module manchester_sync2: 2-flop synchronizer with async active-low reset, output 0.
//  Rest is one FSM with a half-bit counter, a half index, a pair buffer and a shift register.
// TESTING (HALF_BIT=4)
//  1. mode=0, send 8'hB2 -> data_valid once at T0+71, data_out=8'hB2, code_err=0.
//  2. mode=1, send same line waveform as test 1 -> data_out=8'h4D; then 8'hF0 in IEEE -> 8'hF0.
//  3. Cell 3 of 8'h0F forced to "11" -> code_err pulses once, data_valid=0, data_out keeps prior value.
//  4. Glitch: line high 3 clk, then low -> rejected in START, busy falls, no pulse; next 8'h55 decodes.
//  5. rst_n low for 2 clk mid-DATA -> all outputs 0, no pulse; following 8'hA5 frame decodes correctly.
//  6. Back-to-back 8'hFF then 8'h00, one half-bit low gap -> two data_valid pulses, values correct.

Source files
------------

// File: rtl/manchester_pkg.sv
// rtl/manchester_pkg.sv - shared types and constants for the Manchester receiver
package manchester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_DONE  = 2'd3
    } rx_state_t;

    // Polarity of a '1' cell: THOMAS = high-then-low, IEEE = low-then-high
    localparam logic MODE_THOMAS = 1'b0;
    localparam logic MODE_IEEE   = 1'b1;

    localparam int DEF_HALF_BIT  = 4;
    localparam int DEF_DATA_BITS = 8;

    // Half-bit samples per frame: two start halves plus two per data cell
    function automatic int frame_halves(input int data_bits);
        return 2 * data_bits + 2;
    endfunction

endpackage

// File: rtl/manchester_sync2.sv
// rtl/manchester_sync2.sv - two-flop synchronizer for the asynchronous serial line
module manchester_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; the first may go metastable, the second settles it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/manchester_serial_rx.sv
// rtl/manchester_serial_rx.sv - Manchester serial receiver with code-violation check
module manchester_serial_rx
    import manchester_pkg::*;
#(
    parameter int HALF_BIT  = DEF_HALF_BIT,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 line_in,
    input  logic                 mode,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 code_err,
    output logic                 busy
);

    localparam int HALVES = frame_halves(DATA_BITS);
    localparam int CNT_W  = $clog2(HALF_BIT);
    localparam int HIDX_W = $clog2(HALVES);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(HALF_BIT - 1);
    // Counter restarts one cycle after T0, so mid-half lands on HALF_BIT/2-1
    localparam logic [CNT_W-1:0]  CNT_MID   = CNT_W'(HALF_BIT / 2 - 1);
    localparam logic [HIDX_W-1:0] HIDX_LAST = HIDX_W'(HALVES - 1);
    localparam logic [HIDX_W-1:0] HIDX_ONE  = HIDX_W'(1);

    logic w_line;

    rx_state_t             r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [HIDX_W-1:0]     r_hidx;
    logic                  r_prev;
    logic                  r_mode;
    logic                  r_pair;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_err;

    rx_state_t             w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [HIDX_W-1:0]     w_hidx_nxt;
    logic                  w_mode_nxt;
    logic                  w_pair_nxt;
    logic [DATA_BITS-1:0]  w_shift_nxt;
    logic                  w_err_nxt;
    logic [DATA_BITS-1:0]  w_dout_nxt;
    logic                  w_dv_nxt;
    logic                  w_ce_nxt;
    logic                  w_busy_nxt;
    logic                  w_sample;
    logic                  w_cell_ok;
    logic                  w_cell_bit;

    manchester_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (line_in),
        .o_q   (w_line)
    );

    assign w_sample   = (r_cnt == CNT_MID);
    // A legal cell always has a transition in the middle
    assign w_cell_ok  = r_pair ^ w_line;
    assign w_cell_bit = (r_mode == MODE_IEEE) ? w_line : r_pair;

    // Next-state and output decode for the frame FSM
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
        w_hidx_nxt  = r_hidx;
        w_mode_nxt  = r_mode;
        w_pair_nxt  = r_pair;
        w_shift_nxt = r_shift;
        w_err_nxt   = r_err;
        w_dout_nxt  = data_out;
        w_dv_nxt    = 1'b0;
        w_ce_nxt    = 1'b0;
        w_busy_nxt  = busy;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_line && !r_prev) begin
                    w_state_nxt = ST_START;
                    w_mode_nxt  = mode;
                    w_busy_nxt  = 1'b1;
                    w_hidx_nxt  = '0;
                    w_shift_nxt = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            ST_START: begin
                if (w_sample) begin
                    if (!w_line) begin
                        // Too short to be a start symbol: treat as a glitch
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_hidx_nxt = r_hidx + HIDX_W'(1);
                        if (r_hidx == HIDX_ONE) begin
                            w_state_nxt = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (w_sample) begin
                    w_hidx_nxt = r_hidx + HIDX_W'(1);
                    if (!r_hidx[0]) begin
                        w_pair_nxt = w_line;
                    end else begin
                        w_shift_nxt = {r_shift[DATA_BITS-2:0], w_cell_ok & w_cell_bit};
                        w_err_nxt   = r_err | ~w_cell_ok;
                        if (r_hidx == HIDX_LAST) begin
                            w_state_nxt = ST_DONE;
                            if (w_err_nxt) begin
                                w_ce_nxt = 1'b1;
                            end else begin
                                w_dv_nxt   = 1'b1;
                                w_dout_nxt = w_shift_nxt;
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_err_nxt   = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_hidx     <= '0;
            r_prev     <= 1'b0;
            r_mode     <= MODE_THOMAS;
            r_pair     <= 1'b0;
            r_shift    <= '0;
            r_err      <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            code_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hidx     <= w_hidx_nxt;
            r_prev     <= w_line;
            r_mode     <= w_mode_nxt;
            r_pair     <= w_pair_nxt;
            r_shift    <= w_shift_nxt;
            r_err      <= w_err_nxt;
            data_out   <= w_dout_nxt;
            data_valid <= w_dv_nxt;
            code_err   <= w_ce_nxt;
            busy       <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_manchester_serial_rx.sv
// tb/tb_manchester_serial_rx.sv - randomized self-checking bench for manchester_serial_rx
module tb_manchester_serial_rx;

    localparam int HB  = 4;
    localparam int DB  = 8;
    localparam int NH  = 2 * DB + 2;
    // Two synchronizer flops plus edge detect, then the last mid-half sample
    localparam int LAT = 3 + (2 * DB + 1) * HB + HB / 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          line_in;
    logic          mode;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          code_err;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ev_n  = 0;
    int ev_cyc = 0;
    int ev_kind = 0;
    logic [DB-1:0] exp_hold;

    manchester_serial_rx #(.HALF_BIT(HB), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_in    (line_in),
        .mode       (mode),
        .data_out   (data_out),
        .data_valid (data_valid),
        .code_err   (code_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pulse with its cycle and kind (1=valid, 2=error, 3=both)
    always @(negedge clk) begin
        if (data_valid || code_err) begin
            ev_n    = ev_n + 1;
            ev_cyc  = cyc;
            ev_kind = {30'd0, code_err, data_valid};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Half-bit line levels for a byte: start halves then one cell per bit, MSB first
    function automatic logic [NH-1:0] encode(input logic [DB-1:0] b, input logic m);
        logic [NH-1:0] h;
        h = '0;
        h[0] = 1'b1;
        h[1] = 1'b1;
        for (int i = 0; i < DB; i++) begin
            h[2*i+2] = m ? ~b[DB-1-i] : b[DB-1-i];
            h[2*i+3] = ~h[2*i+2];
        end
        return h;
    endfunction

    // Reference decode straight from the cell rules
    task automatic decode(input logic [NH-1:0] h, input logic m,
                          output logic [DB-1:0] b, output logic e);
        b = '0;
        e = 1'b0;
        for (int i = 0; i < DB; i++) begin
            if (h[2*i+2] == h[2*i+3]) e = 1'b1;
            else b[DB-1-i] = m ? h[2*i+3] : h[2*i+2];
        end
    endtask

    task automatic send_frame(input logic [NH-1:0] h, input logic m, input int gap,
                              input string tag);
        int c0;
        int n0;
        logic [DB-1:0] eb;
        logic ee;
        decode(h, m, eb, ee);
        mode = m;
        n0 = ev_n;
        c0 = cyc;
        for (int k = 0; k < NH; k++) begin
            for (int j = 0; j < HB; j++) begin
                line_in = h[k];
                if (k == 1 && j == 0) chk({tag, "_busy"}, 32'(busy), 32'd1);
                if (k == 2 && j == 0) mode = 1'($urandom_range(0, 1));
                tick();
            end
        end
        line_in = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        if (!ee) exp_hold = eb;
        chk({tag, "_npulse"}, 32'(ev_n - n0), 32'd1);
        chk({tag, "_pcyc"}, 32'(ev_cyc - c0), 32'(LAT));
        chk({tag, "_kind"}, 32'(ev_kind), ee ? 32'd2 : 32'd1);
        chk({tag, "_data"}, 32'(data_out), 32'(exp_hold));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    logic [NH-1:0] h;
    logic [DB-1:0] rb;
    int n0;
    int c0;

    initial begin
        rst_n   = 1'b0;
        line_in = 1'b0;
        mode    = 1'b0;
        exp_hold = '0;
        tick();
        tick();
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_flags", {29'd0, data_valid, code_err, busy}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        send_frame(encode(8'hB2, 1'b0), 1'b0, 8, "t1_b2");
        send_frame(encode(8'hB2, 1'b0), 1'b1, 8, "t2_4d");
        chk("t2_val", 32'(data_out), 32'h4D);
        send_frame(encode(8'hF0, 1'b1), 1'b1, 8, "t2_f0");

        h = encode(8'h0F, 1'b0);
        h[8] = 1'b1;
        h[9] = 1'b1;
        send_frame(h, 1'b0, 8, "t3_viol");
        chk("t3_keep", 32'(data_out), 32'hF0);

        // Short pulse: must be rejected at the second start sample
        n0 = ev_n;
        c0 = cyc;
        line_in = 1'b1;
        tick();
        tick();
        tick();
        line_in = 1'b0;
        tick();
        chk("t4_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 20; i++) tick();
        chk("t4_busy_low", 32'(busy), 32'd0);
        chk("t4_nopulse", 32'(ev_n - n0), 32'd0);
        send_frame(encode(8'h55, 1'b0), 1'b0, 8, "t4_55");

        // Reset in the middle of the data cells
        n0 = ev_n;
        h = encode(8'h3C, 1'b0);
        for (int n = 0; n < 30; n++) begin
            line_in = h[n / HB];
            tick();
        end
        line_in = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("t5_data", 32'(data_out), 32'd0);
        chk("t5_flags", {29'd0, data_valid, code_err, busy}, 32'd0);
        rst_n = 1'b1;
        exp_hold = '0;
        for (int i = 0; i < 90; i++) tick();
        chk("t5_nopulse", 32'(ev_n - n0), 32'd0);
        send_frame(encode(8'hA5, 1'b0), 1'b0, 8, "t5_a5");

        send_frame(encode(8'hFF, 1'b0), 1'b0, HB, "t6_ff");
        send_frame(encode(8'h00, 1'b0), 1'b0, HB, "t6_00");

        for (int r = 0; r < 25; r++) begin
            rb = DB'($urandom);
            h = encode(rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                int c;
                c = $urandom_range(0, DB - 1);
                h[2*c+2] = 1'($urandom_range(0, 1));
                h[2*c+3] = h[2*c+2];
            end
            send_frame(h, 1'($urandom_range(0, 1)), $urandom_range(HB, 3 * HB), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
